// File: rtl/eight_bit_serial_transmitter.sv
// Parallel-to-serial transmitter: accepts one byte over valid/ready and sends
// it as start bit (0), eight data bits LSB-first, then stop bit (1).
module eight_bit_serial_transmitter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CYC = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] cyc_cnt_q, cyc_cnt_d;
  logic       done_q, done_d;
  logic       bit_end;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      cyc_cnt_q <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      done_q    <= done_d;
    end
  end

  assign bit_end = (cyc_cnt_q == LAST_CYC);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d   = in;
          cyc_cnt_d = 8'h00;
          state_d   = START;
        end
      end

      START: begin
        if (bit_end) begin
          cyc_cnt_d = 8'h00;
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 8'd1;
        end
      end

      DATA: begin
        if (bit_end) begin
          cyc_cnt_d = 8'h00;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 8'd1;
        end
      end

      STOP: begin
        if (bit_end) begin
          cyc_cnt_d = 8'h00;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; in/in_valid never reach them directly.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign in_ready = (state_q == IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_eight_bit_serial_transmitter.sv
// Directed bench for eight_bit_serial_transmitter: one instance at four clocks
// per bit, one at a single clock per bit, sharing clock and reset.
module tb_eight_bit_serial_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_a, in_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eight_bit_serial_transmitter #(.CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst(rst), .in(in_a), .in_valid(valid_a), .in_ready(ready_a),
    .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  eight_bit_serial_transmitter #(.CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(valid_b), .in_ready(ready_b),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected tx for frame slot 0..9: start, eight data bits LSB-first, stop.
  function automatic logic frame_bit(input logic [7:0] data, input int slot);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return data[slot-1];
  endfunction

  // Called at the negedge of the first start-bit cycle; returns at the negedge
  // of the done cycle, reporting the cycle count at which done was seen.
  task automatic run_frame_a(input logic [7:0] data, input string tag,
                             input bit hold_valid, input int disturb_at,
                             output int done_at);
    for (int c = 0; c < 40; c++) begin
      if (c == 0 && !hold_valid) valid_a = 1'b0;
      check($sformatf("%s tx c%0d", tag, c), tx_a, frame_bit(data, c / 4));
      check($sformatf("%s busy c%0d", tag, c), busy_a, 1'b1);
      check($sformatf("%s ready c%0d", tag, c), ready_a, 1'b0);
      check($sformatf("%s done c%0d", tag, c), done_a, 1'b0);
      if (c == disturb_at) begin
        in_a    = 8'hC3;
        valid_a = 1'b1;
      end
      @(negedge clk);
    end
    done_at = cyc;
    check({tag, " done pulse"}, done_a, 1'b1);
    check({tag, " done busy"}, busy_a, 1'b0);
    check({tag, " done ready"}, ready_a, 1'b1);
    check({tag, " done tx"}, tx_a, 1'b1);
  endtask

  task automatic start_a(input logic [7:0] data);
    in_a    = data;
    valid_a = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int  t0, t1;
    bit  seen;

    // Reset held for three cycles with a word offered: nothing may start.
    rst = 1'b1; in_a = 8'hAA; valid_a = 1'b1; in_b = 8'hAA; valid_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst tx", tx_a, 1'b1);
      check("rst busy", busy_a, 1'b0);
      check("rst done", done_a, 1'b0);
      check("rst ready", ready_a, 1'b1);
      check("rst b tx", tx_b, 1'b1);
      check("rst b busy", busy_b, 1'b0);
    end
    rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    @(negedge clk);
    check("post rst idle busy", busy_a, 1'b0);
    check("post rst idle tx", tx_a, 1'b1);

    // Single frame of 8'hA5.
    start_a(8'hA5);
    run_frame_a(8'hA5, "a5", 1'b0, -1, t0);
    @(negedge clk);
    check("a5 done width", done_a, 1'b0);

    // Back-to-back: 8'h00 with valid held, 8'hFF offered in the done cycle.
    start_a(8'h00);
    run_frame_a(8'h00, "b2b0", 1'b1, -1, t0);
    in_a = 8'hFF;
    @(negedge clk);
    run_frame_a(8'hFF, "b2b1", 1'b0, -1, t1);
    check("b2b done spacing", t1 - t0, 41);
    @(negedge clk);

    // Input disturbance mid-frame must not corrupt the captured word.
    start_a(8'h3C);
    run_frame_a(8'h3C, "dist", 1'b0, 12, t0);
    valid_a = 1'b0;
    @(negedge clk);
    check("dist no restart", busy_a, 1'b0);

    // Reset during data bit 3 of 8'h81.
    start_a(8'h81);
    valid_a = 1'b0;
    repeat (17) @(negedge clk);
    check("rstmid bit3 tx", tx_a, 1'b0);
    check("rstmid bit3 busy", busy_a, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid tx", tx_a, 1'b1);
    check("rstmid busy", busy_a, 1'b0);
    check("rstmid ready", ready_a, 1'b1);
    check("rstmid done", done_a, 1'b0);
    seen = 1'b0;
    repeat (45) begin
      @(negedge clk);
      seen = seen | done_a | busy_a;
    end
    check("rstmid no done/busy", seen, 1'b0);
    start_a(8'h01);
    run_frame_a(8'h01, "after rst", 1'b0, -1, t0);
    @(negedge clk);

    // Minimum rate: one clock per bit, 8'h55.
    in_b = 8'h55; valid_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("min tx c%0d", c), tx_b, frame_bit(8'h55, c));
      check($sformatf("min busy c%0d", c), busy_b, 1'b1);
      check($sformatf("min done c%0d", c), done_b, 1'b0);
      @(negedge clk);
    end
    check("min done c11", done_b, 1'b1);
    check("min idle busy", busy_b, 1'b0);
    check("min idle ready", ready_b, 1'b1);
    @(negedge clk);
    check("min done width", done_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eight_bit_serial_transmitter.md
Name: eight_bit_serial_transmitter

Overview:
Parallel-to-serial transmitter: captures one 8-bit word through a valid/ready handshake and shifts it out on a single line.
Each frame is 1 start bit (0), then 8 data bits LSB-first, then 1 stop bit (1).
It is the serialising counterpart to the team's 8-bit parallel register: it takes a registered byte and drives it onto a 1-bit link.
It feeds the lab's serial link and the matching serial receiver.

Parameters:
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx; legal range 1..255.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in  input  8  parallel data word to transmit
in_valid  input  1  in holds a word to send
in_ready  output  1  block can accept a word this cycle
tx  output  1  serial line; idles high
busy  output  1  frame in progress (start, data or stop bit)
done  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- Reset: rst is sampled on a clk rising edge (synchronous, active-high). On that edge:
  - state=IDLE, tx=1, busy=0, done=0, in_ready=1;
  - shift register, bit counter and cycle counter cleared.
- Reset overrides everything. A reset mid-frame aborts the frame and discards the captured word; tx returns to 1 on the next edge.
- All outputs are registered or decoded from registered state only. No combinational path from in/in_valid to any output.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0, in_ready=1.
  - If in_valid=1 at a rising edge: capture in into the 8-bit shift register, go to START, clear the cycle counter.
- START:
  - tx=0, busy=1, in_ready=0.
  - Held for exactly CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
- DATA:
  - tx=shift_reg[0], busy=1, in_ready=0.
  - Each bit is held for CLKS_PER_BIT cycles. At the end of each bit, shift right and increment the bit counter.
  - After bit 7 completes, go to STOP.
- STOP:
  - tx=1, busy=1, in_ready=0.
  - Held for CLKS_PER_BIT cycles, then go to IDLE and assert done=1 for that first IDLE cycle only.
- Latency: the word accepted at edge k gives tx=0 in the cycle following edge k.
  - A frame occupies exactly 10*CLKS_PER_BIT cycles.
  - done is high in cycle 10*CLKS_PER_BIT+1, counting the first start-bit cycle as cycle 1.
- Back-to-back: in the done cycle, in_ready=1.
  - If in_valid=1 then, the next word is accepted and its start bit begins in the following cycle.
  - Idle gap between frames is 1 cycle (tx=1).
- in and in_valid while busy=1 are ignored. The captured word is immune to later changes of in.
- Cycle counter: width 8 bits; compared against CLKS_PER_BIT-1.
  - CLKS_PER_BIT=1 must work: one cycle per bit, no off-by-one.
- Bit counter: 3 bits. No wrap beyond bit 7. DATA exits exactly after 8 bits.
- done and in_valid acceptance in the same cycle are legal and independent.

Test Plan:
- Single frame: CLKS_PER_BIT=4, in=8'hA5 with in_valid pulse.
  - tx pattern, each held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1.
  - busy=1 for exactly 40 cycles; done=1 for one cycle immediately after; in_ready=0 throughout the frame.
- Back-to-back: in_valid held high with 8'h00, then 8'hFF presented in the done cycle.
  - Frame 1 data bits all 0; one idle cycle of tx=1; frame 2 data bits all 1; two done pulses 41 cycles apart.
- Input disturbance: send 8'h3C, then toggle in to 8'hC3 with in_valid=1 mid-frame.
  - Serialised data is still 8'h3C (0,0,1,1,1,1,0,0 LSB-first); no second frame starts until done.
- Reset mid-frame: assert rst during data bit 3 of 8'h81.
  - Next cycle: tx=1, busy=0, in_ready=1, done never pulses.
  - A following send of 8'h01 transmits cleanly.
- Minimum rate: CLKS_PER_BIT=1, send 8'h55.
  - tx = 0,1,0,1,0,1,0,1,0,1 over 10 consecutive cycles; done in cycle 11.
- Reset value check: hold rst for 3 cycles with in_valid=1.
  - tx=1, busy=0, done=0, in_ready=1; no frame starts until rst is deasserted.
